// File: rtl/riscv_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : riscv_pkg
// Purpose  : Shared opcode constants, ALU operation encoding and the ALU
//            operation selector used by the riscv core.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package riscv_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // addi x0,x0,0
  localparam logic [31:0] NOP = 32'h00000013;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND
  } alu_op_t;

  // funct7[5] selects SUB only for register-register ops (ADDI has no SUBI),
  // but selects SRA/SRAI for both forms.
  function automatic alu_op_t alu_sel(input logic [2:0] funct3,
                                      input logic       funct7b5,
                                      input logic       is_reg);
    alu_op_t op;
    case (funct3)
      3'b000:  op = (is_reg && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_imem.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : imem
// Purpose  : Byte-wide instruction memory with combinational little-endian
//            word fetch. Contents are preloaded from outside the design.
// Ports    : i_addr  [31:0] byte address of the instruction (pc)
//            o_instr [31:0] fetched instruction, NOP when past the end
// Revision : 1.0 - initial release
// ============================================================================
module imem
  import riscv_pkg::*;
#(
  parameter int PROG_SIZE = 1023
) (
  input  logic [31:0] i_addr,
  output logic [31:0] o_instr
);

  localparam int AW = $clog2(PROG_SIZE + 1);

  logic [7:0]    tab_inst [0:PROG_SIZE];
  logic [AW-1:0] w_idx;

  assign w_idx = i_addr[AW-1:0];

  // A word whose top byte would fall beyond PROG_SIZE is treated as NOP, so
  // a pc that runs off the end keeps stepping through NOPs.
  always_comb begin
    if (i_addr > 32'(PROG_SIZE - 3)) begin
      o_instr = NOP;
    end else begin
      o_instr = {tab_inst[w_idx + AW'(3)], tab_inst[w_idx + AW'(2)],
                 tab_inst[w_idx + AW'(1)], tab_inst[w_idx]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/riscv.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : riscv (plus helper modules regfile and dmem)
// Purpose  : Single-cycle RV32I-subset core. One instruction retires on every
//            rising clock edge; decode, ALU and branch compare are inline.
// Ports    : clk  system clock, all state updates on the rising edge
//            rst  asynchronous active-low reset (clears pc, regs, dmem)
// Revision : 1.0 - initial release
// ============================================================================

// Register file: two combinational read ports, one synchronous write port.
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd
);

  logic [31:0] regs [0:31];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (i_we && (i_wa != 5'd0)) begin
      regs[i_wa] <= i_wd;
    end
  end

  assign o_rd1 = (i_ra1 == 5'd0) ? '0 : regs[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? '0 : regs[i_ra2];

endmodule

// Word data memory: combinational read, synchronous write, out-of-range
// accesses read 0 and drop writes.
module dmem #(
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic        i_we,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata
);

  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0]    mem [0:DMEM_WORDS-1];
  logic [DAW-1:0] w_idx;
  logic           w_in_range;
  logic           w_unused;

  assign w_idx      = i_addr[DAW+1:2];
  assign w_in_range = (i_addr[31:2] < 30'(DMEM_WORDS));
  // Byte offset is dropped: misaligned addresses truncate to the word.
  assign w_unused   = &{1'b0, i_addr[1:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DMEM_WORDS; i++) mem[i] <= '0;
    end else if (i_we && w_in_range) begin
      mem[w_idx] <= i_wdata;
    end
  end

  assign o_rdata = w_in_range ? mem[w_idx] : '0;

endmodule

module riscv
  import riscv_pkg::*;
#(
  parameter int PROG_SIZE  = 1023,
  parameter int DMEM_WORDS = 64
) (
  input logic clk,
  input logic rst
);

  logic [31:0] r_pc;
  logic [31:0] w_instr, w_pc_plus4, w_next_pc;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_rd1, w_rd2, w_wd, w_alu_b, w_alu_y, w_daddr, w_drdata;
  logic [6:0]  w_opcode;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic [2:0]  w_funct3;
  logic        w_we, w_dwe, w_take;
  alu_op_t     w_alu_op;

  imem #(.PROG_SIZE(PROG_SIZE)) imem1 (
    .i_addr  (r_pc),
    .o_instr (w_instr)
  );

  regfile rf1 (
    .clk   (clk),
    .rst   (rst),
    .i_ra1 (w_rs1),
    .i_ra2 (w_rs2),
    .o_rd1 (w_rd1),
    .o_rd2 (w_rd2),
    .i_we  (w_we),
    .i_wa  (w_rd),
    .i_wd  (w_wd)
  );

  dmem #(.DMEM_WORDS(DMEM_WORDS)) dmem1 (
    .clk     (clk),
    .rst     (rst),
    .i_addr  (w_daddr),
    .i_we    (w_dwe),
    .i_wdata (w_rd2),
    .o_rdata (w_drdata)
  );

  // Field extraction and sign-extended immediates.
  assign w_opcode = w_instr[6:0];
  assign w_rd     = w_instr[11:7];
  assign w_funct3 = w_instr[14:12];
  assign w_rs1    = w_instr[19:15];
  assign w_rs2    = w_instr[24:20];

  assign w_imm_i = {{20{w_instr[31]}}, w_instr[31:20]};
  assign w_imm_s = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
  assign w_imm_b = {{19{w_instr[31]}}, w_instr[31], w_instr[7],
                    w_instr[30:25], w_instr[11:8], 1'b0};
  assign w_imm_u = {w_instr[31:12], 12'b0};
  assign w_imm_j = {{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                    w_instr[20], w_instr[30:21], 1'b0};

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_daddr    = w_rd1 + ((w_opcode == OP_STORE) ? w_imm_s : w_imm_i);

  // ALU
  assign w_alu_op = alu_sel(w_funct3, w_instr[30], (w_opcode == OP_REG));
  assign w_alu_b  = (w_opcode == OP_REG) ? w_rd2 : w_imm_i;

  always_comb begin
    w_alu_y = w_rd1 + w_alu_b;
    case (w_alu_op)
      ALU_SUB:  w_alu_y = w_rd1 - w_alu_b;
      ALU_SLL:  w_alu_y = w_rd1 << w_alu_b[4:0];
      ALU_SLT:  w_alu_y = {31'b0, $signed(w_rd1) < $signed(w_alu_b)};
      ALU_SLTU: w_alu_y = {31'b0, w_rd1 < w_alu_b};
      ALU_XOR:  w_alu_y = w_rd1 ^ w_alu_b;
      ALU_SRL:  w_alu_y = w_rd1 >> w_alu_b[4:0];
      ALU_SRA:  w_alu_y = 32'($signed(w_rd1) >>> w_alu_b[4:0]);
      ALU_OR:   w_alu_y = w_rd1 | w_alu_b;
      ALU_AND:  w_alu_y = w_rd1 & w_alu_b;
      default:  w_alu_y = w_rd1 + w_alu_b;
    endcase
  end

  // Branch compare; funct3 010/011 are not branches and never take.
  always_comb begin
    w_take = 1'b0;
    case (w_funct3)
      3'b000:  w_take = (w_rd1 == w_rd2);
      3'b001:  w_take = (w_rd1 != w_rd2);
      3'b100:  w_take = ($signed(w_rd1) <  $signed(w_rd2));
      3'b101:  w_take = ($signed(w_rd1) >= $signed(w_rd2));
      3'b110:  w_take = (w_rd1 <  w_rd2);
      3'b111:  w_take = (w_rd1 >= w_rd2);
      default: w_take = 1'b0;
    endcase
  end

  // Control: anything not decoded falls through as a NOP (pc+4, no writes).
  always_comb begin
    w_next_pc = w_pc_plus4;
    w_we      = 1'b0;
    w_wd      = w_alu_y;
    w_dwe     = 1'b0;
    case (w_opcode)
      OP_LUI: begin
        w_we = 1'b1;
        w_wd = w_imm_u;
      end
      OP_AUIPC: begin
        w_we = 1'b1;
        w_wd = r_pc + w_imm_u;
      end
      OP_JAL: begin
        w_we      = 1'b1;
        w_wd      = w_pc_plus4;
        w_next_pc = r_pc + w_imm_j;
      end
      OP_JALR: begin
        if (w_funct3 == 3'b000) begin
          w_we      = 1'b1;
          w_wd      = w_pc_plus4;
          w_next_pc = (w_rd1 + w_imm_i) & ~32'd1;
        end
      end
      OP_BRANCH: begin
        if (w_take) w_next_pc = r_pc + w_imm_b;
      end
      OP_LOAD: begin
        if (w_funct3 == 3'b010) begin
          w_we = 1'b1;
          w_wd = w_drdata;
        end
      end
      OP_STORE: begin
        if (w_funct3 == 3'b010) w_dwe = 1'b1;
      end
      OP_IMM, OP_REG: begin
        w_we = 1'b1;
      end
      default: begin
        w_we = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pc <= '0;
    else      r_pc <= w_next_pc;
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_riscv
// Purpose  : Self-checking bench for the riscv core. Programs are written
//            into the instruction memory while reset is held; expected
//            architectural state is queued per cycle and compared as the
//            core retires instructions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv;

  localparam logic [31:0] NOP_W     = 32'h00000013;
  localparam logic [6:0]  OPC_IMM   = 7'h13;
  localparam logic [6:0]  OPC_REG   = 7'h33;
  localparam logic [6:0]  OPC_LUI   = 7'h37;
  localparam logic [6:0]  OPC_AUIPC = 7'h17;
  localparam logic [6:0]  OPC_LOAD  = 7'h03;
  localparam logic [6:0]  OPC_JALR  = 7'h67;

  // kinds: 0 main reg, 1 main pc, 2 main dmem word, 3 small-core reg, 4 small-core pc
  typedef struct {
    int          cyc;
    int          kind;
    int          idx;
    logic [31:0] exp;
    string       nm;
  } chk_t;

  typedef struct {
    logic [31:0] instr;
    int          rd;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #10 clk = ~clk;

  riscv #(.PROG_SIZE(127), .DMEM_WORDS(64)) dut   (.clk(clk), .rst(rst));
  riscv #(.PROG_SIZE(7),   .DMEM_WORDS(64)) dut_a (.clk(clk), .rst(rst));

  chk_t        sb[$];
  logic [31:0] prog[$];
  int          n_cmp  = 0;
  int          n_fail = 0;

  function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], OPC_REG};
  endfunction
  function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_u(int imm20, int rd, logic [6:0] op);
    return {imm20[19:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] actual(int kind, int idx);
    case (kind)
      0:       return dut.rf1.regs[idx[4:0]];
      1:       return dut.r_pc;
      2:       return dut.dmem1.mem[idx[5:0]];
      3:       return dut_a.rf1.regs[idx[4:0]];
      default: return dut_a.r_pc;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic push(input int cyc, input int kind, input int idx,
                      input logic [31:0] exp, input string nm);
    chk_t c;
    c.cyc = cyc; c.kind = kind; c.idx = idx; c.exp = exp; c.nm = nm;
    sb.push_back(c);
  endtask

  task automatic load_main();
    logic [31:0] w;
    for (int i = 0; i < 128; i++) begin
      w = (i / 4 < prog.size()) ? prog[i / 4] : NOP_W;
      dut.imem1.tab_inst[i] = w[8 * (i % 4) +: 8];
    end
  endtask

  // Hold reset across one rising edge, load the program, release mid-cycle.
  task automatic start_prog();
    @(negedge clk);
    rst = 1'b0;
    #1;
    load_main();
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Advance n retire edges, comparing queued expectations on the falling edge.
  task automatic run(input int n);
    chk_t c;
    for (int cy = 1; cy <= n; cy++) begin
      @(posedge clk);
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc == cy) begin
        c = sb.pop_front();
        check(c.nm, actual(c.kind, c.idx), c.exp);
      end
    end
    while (sb.size() > 0) begin
      c = sb.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL %s: not reached by cycle %0d, want %h", c.nm, n, c.exp);
    end
  endtask

  initial begin
    vec_t        vt[$];
    logic [31:0] wa;
    logic [31:0] prog_a[2];

    // ---------------- reset, pc sequencing, add program, x0/negatives -------
    prog = '{enc_i(7, 0, 0, 0, OPC_IMM), enc_i(-1, 0, 0, 3, OPC_IMM),
             enc_r(7'h20, 3, 0, 0, 4)};
    load_main();
    prog_a[0] = enc_i(5, 0, 0, 1, OPC_IMM);
    prog_a[1] = enc_r(0, 1, 1, 0, 2);
    for (int i = 0; i < 8; i++) begin
      wa = prog_a[i / 4];
      dut_a.imem1.tab_inst[i] = wa[8 * (i % 4) +: 8];
    end

    #15;
    check("reset_pc", dut.r_pc, 32'd0);
    check("reset_pc_a", dut_a.r_pc, 32'd0);
    for (int r = 0; r < 32; r++) check($sformatf("reset_x%0d", r), dut.rf1.regs[r], 32'd0);
    #6;
    rst = 1'b1;

    push(1, 1, 0, 32'd4,  "pc_seq1");
    push(1, 3, 1, 32'd5,  "add_x1");
    push(2, 1, 0, 32'd8,  "pc_seq2");
    push(2, 3, 2, 32'd10, "add_x2");
    push(3, 1, 0, 32'd12, "pc_seq3");
    push(3, 0, 0, 32'd0,  "x0_write_ignored");
    push(3, 0, 3, 32'hFFFF_FFFF, "neg_x3");
    push(3, 0, 4, 32'd1,  "sub_x4");
    push(5, 4, 0, 32'd20, "nop_tail_pc");
    push(5, 3, 1, 32'd5,  "nop_tail_x1");
    push(5, 3, 2, 32'd10, "nop_tail_x2");
    run(5);

    // ---------------- beq not taken, jal, skipped instruction ---------------
    prog = '{enc_i(1, 0, 0, 1, OPC_IMM), enc_b(8, 0, 1, 0), enc_j(8, 5),
             enc_i(9, 0, 0, 6, OPC_IMM)};
    start_prog();
    push(2, 1, 0, 32'd8,  "beq_nt_pc");
    push(3, 1, 0, 32'd16, "jal_pc");
    push(3, 0, 5, 32'd12, "jal_link");
    push(3, 0, 6, 32'd0,  "jal_skipped_x6");
    run(3);

    // ---------------- blt taken, bltu not taken, jalr, out-of-range load ----
    prog = '{enc_i(-1, 0, 0, 1, OPC_IMM), enc_b(8, 0, 1, 4),
             enc_i(1, 0, 0, 6, OPC_IMM),  enc_b(8, 0, 1, 6),
             enc_i(25, 0, 0, 7, OPC_JALR), enc_i(1, 0, 0, 9, OPC_IMM),
             enc_i(3, 0, 0, 8, OPC_IMM),  enc_i(1024, 0, 2, 8, OPC_LOAD)};
    start_prog();
    push(2, 1, 0, 32'd12, "blt_taken_pc");
    push(3, 1, 0, 32'd16, "bltu_nt_pc");
    push(4, 1, 0, 32'd24, "jalr_pc");
    push(4, 0, 7, 32'd20, "jalr_link");
    push(4, 0, 6, 32'd0,  "blt_skipped_x6");
    push(5, 0, 8, 32'd3,  "pre_load_x8");
    push(6, 0, 8, 32'd0,  "lw_oob_zero");
    push(6, 0, 9, 32'd0,  "jalr_skipped_x9");
    run(6);

    // ---------------- store / load, then asynchronous reset mid-program -----
    prog = '{enc_i(32'h55, 0, 0, 1, OPC_IMM), enc_s(8, 1, 0),
             enc_i(8, 0, 2, 2, OPC_LOAD)};
    start_prog();
    push(2, 2, 2, 32'h55, "sw_mem2");
    push(3, 0, 2, 32'h55, "lw_x2");
    run(3);

    #3;
    rst = 1'b0;
    #1;
    check("areset_pc", dut.r_pc, 32'd0);
    check("areset_x1", dut.rf1.regs[1], 32'd0);
    check("areset_x2", dut.rf1.regs[2], 32'd0);
    check("areset_mem2", dut.dmem1.mem[2], 32'd0);
    @(negedge clk);
    rst = 1'b1;
    push(1, 1, 0, 32'd4,  "restart_pc");
    push(3, 0, 2, 32'h55, "restart_x2");
    push(3, 2, 2, 32'h55, "restart_mem2");
    run(3);

    // ---------------- table-driven ALU / upper-immediate vectors ------------
    // Operands: x1 = -8, x2 = 3, x3 = 33 (shift amount uses low 5 bits -> 1).
    vt.push_back('{enc_r(0,     2, 1, 0, 10), 10, 32'hFFFF_FFFB, "add"});
    vt.push_back('{enc_r(7'h20, 2, 1, 0, 11), 11, 32'hFFFF_FFF5, "sub"});
    vt.push_back('{enc_r(0,     2, 1, 1, 12), 12, 32'hFFFF_FFC0, "sll"});
    vt.push_back('{enc_r(0,     2, 1, 2, 13), 13, 32'd1,         "slt"});
    vt.push_back('{enc_r(0,     2, 1, 3, 14), 14, 32'd0,         "sltu"});
    vt.push_back('{enc_r(0,     2, 1, 4, 15), 15, 32'hFFFF_FFFB, "xor"});
    vt.push_back('{enc_r(0,     2, 1, 5, 16), 16, 32'h1FFF_FFFF, "srl"});
    vt.push_back('{enc_r(7'h20, 2, 1, 5, 17), 17, 32'hFFFF_FFFF, "sra"});
    vt.push_back('{enc_r(0,     2, 1, 6, 18), 18, 32'hFFFF_FFFB, "or"});
    vt.push_back('{enc_r(0,     2, 1, 7, 19), 19, 32'd0,         "and"});
    vt.push_back('{enc_i(-7,     1, 2, 20, OPC_IMM), 20, 32'd1,  "slti"});
    vt.push_back('{enc_i(-1,     2, 3, 21, OPC_IMM), 21, 32'd1,  "sltiu"});
    vt.push_back('{enc_i(-1,     1, 4, 22, OPC_IMM), 22, 32'd7,  "xori"});
    vt.push_back('{enc_i(32'h401, 1, 5, 23, OPC_IMM), 23, 32'hFFFF_FFFC, "srai"});
    vt.push_back('{enc_u(32'h12345, 24, OPC_LUI), 24, 32'h1234_5000, "lui"});
    vt.push_back('{enc_r(0,     3, 2, 1, 26), 26, 32'd6,         "sll_amt33"});
    // auipc sits at instruction 19 (3 preamble + index 16) -> pc 76
    vt.push_back('{enc_u(1, 25, OPC_AUIPC), 25, 32'h0000_104C, "auipc"});

    prog = '{enc_i(-8, 0, 0, 1, OPC_IMM), enc_i(3, 0, 0, 2, OPC_IMM),
             enc_i(33, 0, 0, 3, OPC_IMM)};
    for (int i = 0; i < vt.size(); i++) prog.push_back(vt[i].instr);
    start_prog();
    for (int i = 0; i < vt.size(); i++) push(20, 0, vt[i].rd, vt[i].exp, vt[i].nm);
    push(20, 1, 0, 32'd80, "alu_prog_pc");
    run(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
